gpr_writeback_unit: RTL and testbench

- Write-back stage directly upstream of the general purpose register file.
- Accepts sized register-write requests (8L/8H/16/32-bit, optionally paired with a second 32-bit write) from the execute stage through a valid/ready handshake, and buffers them in a small FIFO.
- Merges each partial write with the current 32-bit register value, forwarding from its own in-flight write.
- Drives the register file's single full-width write port (write_enable/write_index/write_data), at most one write per cycle.

---
 rtl/gpr_writeback_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_gpr_writeback_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_writeback_unit.sv
// ---------------------------------------------------------------------------
// gpr_writeback_unit
//
// Write-back stage sitting directly in front of the general purpose register
// file. Sized register-write requests (byte low, byte high, word, dword, with
// an optional second dword write) arrive over a valid/ready handshake and are
// buffered in a small FIFO. A two-state drain FSM merges each partial write
// with the current 32-bit register value and drives the register file's
// single full-width write port, at most one write per cycle.
//
// Optional feature macro: GPR_WB_BYPASS_EN
//   Defined   - a legal request accepted while the FIFO is empty and the FSM
//               is idle issues its first write in the cycle it is accepted.
//   Undefined - every request passes through the FIFO first.
//
// Parameters:
//   DEPTH         FIFO entries (power of two, >= 2)
//
// Ports:
//   clock         clock, rising edge
//   reset         asynchronous reset, active low
//   in_valid      request valid
//   in_ready      request can be accepted (FIFO not full, not in reset)
//   in_size       00 byte low, 01 byte high, 10 word, 11 dword
//   in_index      target register 0..7 (EAX,EBX,ECX,EDX,ESI,EDI,EBP,ESP)
//   in_data       write value, right aligned
//   in_dual       request carries a second dword write
//   in_index2     second write index
//   in_data2      second write value (always dword)
//   gpr_flat      current register file contents, reg i at [32i+31:32i]
//   write_enable  register file write strobe (registered)
//   write_index   register file write index (registered)
//   write_data    merged full 32-bit value (registered)
//   busy          FIFO non-empty or second write pending
//   error         one-cycle pulse: illegal request dropped
// ---------------------------------------------------------------------------
module gpr_writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_size,
  input  logic [2:0]   in_index,
  input  logic [31:0]  in_data,
  input  logic         in_dual,
  input  logic [2:0]   in_index2,
  input  logic [31:0]  in_data2,
  input  logic [255:0] gpr_flat,
  output logic         write_enable,
  output logic [2:0]   write_index,
  output logic [31:0]  write_data,
  output logic         busy,
  output logic         error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] SZ_BYTE_LO = 2'b00;
  localparam logic [1:0] SZ_BYTE_HI = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;

  typedef struct packed {
    logic [1:0]  size;
    logic [2:0]  index;
    logic [31:0] data;
    logic        dual;
    logic [2:0]  index2;
    logic [31:0] data2;
  } entry_t;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  // FIFO storage and pointers; the pointers carry one extra bit so that a
  // full FIFO (same slot, different lap) differs from an empty one.
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  state_t        state_q, state_d;
  logic          write_enable_q, write_enable_d;
  logic [2:0]    write_index_q, write_index_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          error_q, error_d;

  logic          full;
  logic          empty;
  entry_t        head;
  logic          accept;
  logic          illegal;
  logic          push_ok;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          first_issue;
  logic [1:0]    first_size;
  logic [2:0]    first_index;
  logic [31:0]   first_data;
  logic          first_dual;
  logic [31:0]   merge_base;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  // in_ready is gated by reset so nothing is accepted while reset is held.
  assign in_ready = reset && !full;
  assign accept   = in_valid && in_ready;
  // A high-byte write only exists for EAX..EDX; the others have no AH-style alias.
  assign illegal  = (in_size == SZ_BYTE_HI) && in_index[2];
  assign push_ok  = accept && !illegal;

`ifdef GPR_WB_BYPASS_EN
  assign bypass   = push_ok && empty && (state_q == ST_FIRST);
`else
  assign bypass   = 1'b0;
`endif

  // A bypassed single write never needs storage; a bypassed dual request is
  // still stored so its second write can issue from the FIFO head.
  assign push     = push_ok && !(bypass && !in_dual);

  function automatic logic [31:0] merge(input logic [1:0]  size,
                                        input logic [31:0] base,
                                        input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_BYTE_LO: r = {base[31:8], d[7:0]};
      SZ_BYTE_HI: r = {base[31:16], d[7:0], base[7:0]};
      SZ_WORD:    r = {base[31:16], d[15:0]};
      default:    r = d;
    endcase
    return r;
  endfunction

  // Pick the source of a first write: the FIFO head normally, or the incoming
  // request when it bypasses an idle, empty unit.
  always_comb begin
    first_issue = 1'b0;
    first_size  = head.size;
    first_index = head.index;
    first_data  = head.data;
    first_dual  = head.dual;
    if (state_q == ST_FIRST) begin
      if (!empty) begin
        first_issue = 1'b1;
      end else if (bypass) begin
        first_issue = 1'b1;
        first_size  = in_size;
        first_index = in_index;
        first_data  = in_data;
        first_dual  = in_dual;
      end
    end
  end

  // The register file only sees our current write at the coming edge, so a
  // write to the same register must merge onto the value we are driving now.
  always_comb begin
    if (write_enable_q && (write_index_q == first_index)) begin
      merge_base = write_data_q;
    end else begin
      merge_base = gpr_flat[{first_index, 5'b00000} +: 32];
    end
  end

  always_comb begin
    state_d        = state_q;
    write_enable_d = 1'b0;
    write_index_d  = write_index_q;
    write_data_d   = write_data_q;
    error_d        = accept && illegal;
    pop            = 1'b0;
    if (state_q == ST_SECOND) begin
      write_enable_d = 1'b1;
      write_index_d  = head.index2;
      write_data_d   = head.data2;
      pop            = 1'b1;
      state_d        = ST_FIRST;
    end else if (first_issue) begin
      write_enable_d = 1'b1;
      write_index_d  = first_index;
      write_data_d   = merge(first_size, merge_base, first_data);
      if (first_dual) begin
        state_d = ST_SECOND;
      end else if (!empty) begin
        pop = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]].size   = in_size;
      mem_d[wr_ptr_q[AW-1:0]].index  = in_index;
      mem_d[wr_ptr_q[AW-1:0]].data   = in_data;
      mem_d[wr_ptr_q[AW-1:0]].dual   = in_dual;
      mem_d[wr_ptr_q[AW-1:0]].index2 = in_index2;
      mem_d[wr_ptr_q[AW-1:0]].data2  = in_data2;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_FIRST;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      write_enable_q <= 1'b0;
      write_index_q  <= 3'd0;
      write_data_q   <= 32'd0;
      error_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      write_enable_q <= write_enable_d;
      write_index_q  <= write_index_d;
      write_data_q   <= write_data_d;
      error_q        <= error_d;
      mem_q          <= mem_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_index  = write_index_q;
  assign write_data   = write_data_q;
  assign error        = error_q;
  assign busy         = !empty || (state_q == ST_SECOND);

endmodule

// File: tb/tb_gpr_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_gpr_writeback_unit
//
// Self-checking bench for gpr_writeback_unit (DEPTH=2). A small register file
// model absorbs the DUT's writes, and a sequential architectural model of the
// registers predicts every write the DUT should produce, in acceptance order.
// Works with or without GPR_WB_BYPASS_EN (only first-write latency and the
// FIFO-full stall expectation differ).
// ---------------------------------------------------------------------------
module tb_gpr_writeback_unit;

`ifdef GPR_WB_BYPASS_EN
  localparam int LAT_OFS = 0;
`else
  localparam int LAT_OFS = 1;
`endif

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [31:0] data;
  } obs_t;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_size;
  logic [2:0]   in_index;
  logic [31:0]  in_data;
  logic         in_dual;
  logic [2:0]   in_index2;
  logic [31:0]  in_data2;
  logic [255:0] gpr_flat;
  logic         write_enable;
  logic [2:0]   write_index;
  logic [31:0]  write_data;
  logic         busy;
  logic         error;

  logic [31:0]  rf [8];
  logic [31:0]  rf_init [8];
  logic         load_rf;
  logic         rf_live;
  logic [31:0]  mregs [8];

  int           cyc;
  int           tests;
  int           failures;
  int           err_seen;
  int           exp_err;
  int           stalls;
  obs_t         obs [$];
  wr_t          exp_q [$];

  gpr_writeback_unit #(.DEPTH(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_size      (in_size),
    .in_index     (in_index),
    .in_data      (in_data),
    .in_dual      (in_dual),
    .in_index2    (in_index2),
    .in_data2     (in_data2),
    .gpr_flat     (gpr_flat),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_data   (write_data),
    .busy         (busy),
    .error        (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Register file model: absorbs writes when live, or loads a preset.
  always @(posedge clock) begin
    if (load_rf) begin
      for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
    end else if (rf_live && write_enable) begin
      rf[write_index] <= write_data;
    end
  end

  always_comb begin
    gpr_flat = '0;
    for (int i = 0; i < 8; i++) gpr_flat[32*i +: 32] = rf[i];
  end

  // Record every register file write and error pulse.
  always @(negedge clock) begin
    if (write_enable) obs.push_back('{cyc, write_index, write_data});
    if (error) err_seen = err_seen + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] apply_write(input logic [1:0] sz,
                                              input logic [31:0] old,
                                              input logic [31:0] d);
    case (sz)
      2'b00:   return (old & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
      2'b01:   return (old & 32'hFFFF_00FF) | ((d & 32'h0000_00FF) << 8);
      2'b10:   return (old & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
      default: return d;
    endcase
  endfunction

  task automatic model_accept(input logic [1:0] sz, input logic [2:0] ix,
                              input logic [31:0] d, input logic du,
                              input logic [2:0] ix2, input logic [31:0] d2);
    logic [31:0] v;
    if (sz == 2'b01 && ix >= 3'd4) begin
      exp_err++;
    end else begin
      v = apply_write(sz, mregs[ix], d);
      mregs[ix] = v;
      exp_q.push_back('{ix, v});
      if (du) begin
        mregs[ix2] = d2;
        exp_q.push_back('{ix2, d2});
      end
    end
  endtask

  task automatic preset_rf();
    @(negedge clock);
    load_rf = 1'b1;
    @(posedge clock);
    #1 load_rf = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = rf_init[i];
    obs.delete();
    exp_q.delete();
  endtask

  // Drives one request and returns the number of the edge that accepted it.
  task automatic send(input logic [1:0] sz, input logic [2:0] ix,
                      input logic [31:0] d, input logic du,
                      input logic [2:0] ix2, input logic [31:0] d2,
                      output int acc);
    int n;
    n = 0;
    @(negedge clock);
    in_size = sz; in_index = ix; in_data = d;
    in_dual = du; in_index2 = ix2; in_data2 = d2;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    stalls += n;
    if (!in_ready) begin
      tests++; failures++;
      $display("[TB] FAIL accept_timeout in_ready=%b, wanted 1", in_ready);
      acc = -1;
      in_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      model_accept(sz, ix, d, du, ix2, d2);
      @(posedge clock);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clock);
    in_valid = 1'b0;
    while ((busy || write_enable) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy || write_enable) begin
      tests++; failures++;
      $display("[TB] FAIL drain_timeout busy=%b we=%b, wanted idle", busy, write_enable);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0;
    #2;
    tests++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_we got %b want 0", write_enable); end
    tests++; if (write_index !== 3'd0) begin failures++; $display("[TB] FAIL reset_idx got %0d want 0", write_index); end
    tests++; if (write_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_data got %h want 0", write_data); end
    tests++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL reset_error got %b want 0", error); end
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b want 0", in_ready); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_dword();
    int acc;
    for (int i = 0; i < 8; i++) rf_init[i] = 32'h0;
    rf_init[0] = 32'h1122_3344;
    preset_rf();
    send(2'b11, 3'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'h0, acc);
    drain();
    tests++; if (obs.size() != 1) begin failures++; $display("[TB] FAIL dword_count got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      tests++; if (obs[0].idx !== 3'd0 || obs[0].data !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL dword_write got %0d/%h want 0/deadbeef", obs[0].idx, obs[0].data); end
      tests++; if (obs[0].cyc != acc + LAT_OFS) begin failures++; $display("[TB] FAIL dword_latency got cycle %0d want %0d", obs[0].cyc, acc + LAT_OFS); end
    end
  endtask

  task automatic test_byte_high();
    int acc;
    rf_init[2] = 32'hAABB_CCDD;
    preset_rf();
    send(2'b01, 3'd2, 32'h0000_005A, 1'b0, 3'd0, 32'h0, acc);
    drain();
    tests++; if (obs.size() != 1) begin failures++; $display("[TB] FAIL bytehi_count got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      tests++; if (obs[0].idx !== 3'd2 || obs[0].data !== 32'hAABB_5ADD) begin failures++; $display("[TB] FAIL bytehi_write got %0d/%h want 2/aabb5add", obs[0].idx, obs[0].data); end
    end
  endtask

  task automatic test_forward_stale();
    int acc;
    rf_init[1] = 32'h0;
    preset_rf();
    rf_live = 1'b0;
    send(2'b10, 3'd1, 32'h0000_1234, 1'b0, 3'd0, 32'h0, acc);
    send(2'b00, 3'd1, 32'h0000_0099, 1'b0, 3'd0, 32'h0, acc);
    drain();
    rf_live = 1'b1;
    tests++; if (obs.size() != 2) begin failures++; $display("[TB] FAIL fwd_count got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      tests++; if (obs[0].data !== 32'h0000_1234) begin failures++; $display("[TB] FAIL fwd_first got %h want 00001234", obs[0].data); end
      tests++; if (obs[1].data !== 32'h0000_1299) begin failures++; $display("[TB] FAIL fwd_second got %h want 00001299", obs[1].data); end
      tests++; if (obs[1].cyc != obs[0].cyc + 1) begin failures++; $display("[TB] FAIL fwd_gap got cycles %0d,%0d want consecutive", obs[0].cyc, obs[1].cyc); end
    end
  endtask

  task automatic test_dual();
    int acc;
    rf_init[0] = 32'h55; rf_init[7] = 32'h0;
    preset_rf();
    send(2'b11, 3'd0, 32'h1, 1'b1, 3'd7, 32'h0000_0FFC, acc);
    @(negedge clock);
    in_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL dual_busy got %b want 1", busy); end
    drain();
    tests++; if (obs.size() != 2) begin failures++; $display("[TB] FAIL dual_count got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      tests++; if (obs[0].idx !== 3'd0 || obs[0].data !== 32'h1) begin failures++; $display("[TB] FAIL dual_first got %0d/%h want 0/1", obs[0].idx, obs[0].data); end
      tests++; if (obs[1].idx !== 3'd7 || obs[1].data !== 32'hFFC) begin failures++; $display("[TB] FAIL dual_second got %0d/%h want 7/ffc", obs[1].idx, obs[1].data); end
      tests++; if (obs[1].cyc != obs[0].cyc + 1) begin failures++; $display("[TB] FAIL dual_gap got cycles %0d,%0d want consecutive", obs[0].cyc, obs[1].cyc); end
    end
  endtask

  task automatic test_full();
    int acc;
    for (int i = 0; i < 8; i++) rf_init[i] = 32'h0101_0101 * i;
    preset_rf();
    stalls = 0;
    send(2'b11, 3'd0, 32'h10, 1'b1, 3'd1, 32'h20, acc);
    send(2'b11, 3'd2, 32'h30, 1'b0, 3'd0, 32'h0, acc);
    send(2'b10, 3'd3, 32'h4444, 1'b0, 3'd0, 32'h0, acc);
    drain();
`ifndef GPR_WB_BYPASS_EN
    tests++; if (stalls == 0) begin failures++; $display("[TB] FAIL full_stall got %0d stall cycles want >0", stalls); end
`endif
    tests++; if (obs.size() != exp_q.size()) begin failures++; $display("[TB] FAIL full_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs[i].idx !== exp_q[i].idx || obs[i].data !== exp_q[i].data) begin
        failures++;
        $display("[TB] FAIL full_write%0d got %0d/%h want %0d/%h", i, obs[i].idx, obs[i].data, exp_q[i].idx, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    int acc;
    int err0;
    for (int i = 0; i < 8; i++) rf_init[i] = $urandom;
    preset_rf();
    err0 = err_seen;
    exp_err = 0;
    for (int n = 0; n < 60; n++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom, acc);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    drain();
    tests++; if (obs.size() != exp_q.size()) begin failures++; $display("[TB] FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs[i].idx !== exp_q[i].idx || obs[i].data !== exp_q[i].data) begin
        failures++;
        $display("[TB] FAIL rand_write%0d got %0d/%h want %0d/%h", i, obs[i].idx, obs[i].data, exp_q[i].idx, exp_q[i].data);
      end
    end
    tests++; if (err_seen - err0 != exp_err) begin failures++; $display("[TB] FAIL rand_errors got %0d want %0d", err_seen - err0, exp_err); end
  endtask

  task automatic test_illegal_and_reset();
    int acc;
    int err0;
    preset_rf();
    err0 = err_seen;
    send(2'b01, 3'd4, 32'h77, 1'b1, 3'd5, 32'h88, acc);
    @(negedge clock);
    in_valid = 1'b0;
    tests++; if (error !== 1'b1) begin failures++; $display("[TB] FAIL illegal_pulse got %b want 1", error); end
    @(negedge clock);
    tests++; if (error !== 1'b0) begin failures++; $display("[TB] FAIL illegal_pulse_end got %b want 0", error); end
    drain();
    tests++; if (obs.size() != 0) begin failures++; $display("[TB] FAIL illegal_writes got %0d want 0", obs.size()); end
    tests++; if (err_seen - err0 != 1) begin failures++; $display("[TB] FAIL illegal_count got %0d want 1", err_seen - err0); end

    send(2'b11, 3'd3, 32'hA, 1'b0, 3'd0, 32'h0, acc);
    send(2'b11, 3'd5, 32'hB, 1'b0, 3'd0, 32'h0, acc);
    @(negedge clock);
    in_valid = 1'b0;
    tests++; if (write_enable !== 1'b1) begin failures++; $display("[TB] FAIL middrain_we got %b want 1", write_enable); end
    reset = 1'b0;
    #1;
    tests++; if (write_enable !== 1'b0) begin failures++; $display("[TB] FAIL rst_we got %b want 0", write_enable); end
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready got %b want 0", in_ready); end
    @(negedge clock);
    reset = 1'b1;
    obs.delete();
    repeat (6) @(negedge clock);
    tests++; if (obs.size() != 0) begin failures++; $display("[TB] FAIL rst_leak got %0d writes want 0", obs.size()); end
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_idle_busy got %b want 0", busy); end
  endtask

  initial begin
    tests = 0; failures = 0; err_seen = 0; exp_err = 0; stalls = 0; cyc = 0;
    load_rf = 1'b0; rf_live = 1'b1;
    in_valid = 1'b0; in_size = 2'b00; in_index = 3'd0; in_data = 32'h0;
    in_dual = 1'b0; in_index2 = 3'd0; in_data2 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      rf_init[i] = 32'h0;
      mregs[i] = 32'h0;
    end
    test_reset();
    preset_rf();
    test_dword();
    test_byte_high();
    test_forward_stale();
    test_dual();
    test_full();
    test_random();
    test_illegal_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
